mesm6_memctl: RTL and testbench



---
 rtl/mesm6_defines.sv | 15 +
 rtl/mesm6_ram.sv | 26 ++
 rtl/mesm6_memctl.sv | 119 +++++++++++
 tb/tb_mesm6_memctl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mesm6_defines.sv
// Shared constants and state encodings for the MESM-6 memory controller.
// Imported by the controller and the RAM macro.
package mesm6_defines;

  localparam int MEM_WAIT_BITS = 4;
  localparam int MEM_WORD_BITS = 48;

  typedef enum logic [1:0] {
    MEM_STATE_IDLE  = 2'd0,
    MEM_STATE_D_ACC = 2'd1,
    MEM_STATE_I_ACC = 2'd2,
    MEM_STATE_RESP  = 2'd3
  } mem_state_t;

endpackage

// File: rtl/mesm6_ram.sv
// Single-port 48-bit synchronous RAM, read-before-write.
// Contents survive reset.
module mesm6_ram
  import mesm6_defines::*;
#(
  parameter int    ADDR_BITS = 15,
  parameter string INIT_FILE = ""
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [ADDR_BITS-1:0]     addr_i,
  input  logic [MEM_WORD_BITS-1:0] wdata_i,
  output logic [MEM_WORD_BITS-1:0] rdata_o
);

  logic [MEM_WORD_BITS-1:0] mem [2**ADDR_BITS];
  logic [MEM_WORD_BITS-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem[addr_i] <= wdata_i;
    rdata_q <= mem[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mesm6_memctl.sv
// Arbitrates the MESM-6 fetch and data buses onto one RAM port.
// Data goes first; both done pulses are issued together in RESP.
module mesm6_memctl
  import mesm6_defines::*;
#(
  parameter int    ADDR_BITS   = 15,
  parameter int    WAIT_STATES = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ibus_fetch,
  input  logic [14:0] ibus_addr,
  output logic [47:0] ibus_input,
  output logic        ibus_done,
  input  logic        dbus_read,
  input  logic        dbus_write,
  input  logic [14:0] dbus_addr,
  input  logic [47:0] dbus_output,
  output logic [47:0] dbus_input,
  output logic        dbus_done
);

  localparam logic [MEM_WAIT_BITS-1:0] WS =
    MEM_WAIT_BITS'(WAIT_STATES);

  mem_state_t state_q, state_d;
  logic [MEM_WAIT_BITS-1:0] cnt_q, cnt_d;
  logic pend_i_q, pend_d_q, rd_q, wr_q;
  logic cap_i_q, cap_d_q;
  logic [ADDR_BITS-1:0] i_addr_q, d_addr_q;
  logic [47:0] wdata_q, ibus_in_q, dbus_in_q;

  logic dreq, acc, last, ram_we;
  logic [ADDR_BITS-1:0] ram_addr;
  logic [47:0] ram_rdata;

  assign dreq = dbus_read | dbus_write;
  assign acc  = (state_q == MEM_STATE_D_ACC) |
                (state_q == MEM_STATE_I_ACC);
  assign last = acc & (cnt_q == WS);

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    if (acc && !last) cnt_d = cnt_q + 1'b1;
    unique case (state_q)
      MEM_STATE_IDLE: begin
        if (dreq)            state_d = MEM_STATE_D_ACC;
        else if (ibus_fetch) state_d = MEM_STATE_I_ACC;
      end
      MEM_STATE_D_ACC: begin
        if (last)
          state_d = pend_i_q ? MEM_STATE_I_ACC
                             : MEM_STATE_RESP;
      end
      MEM_STATE_I_ACC: begin
        if (last) state_d = MEM_STATE_RESP;
      end
      MEM_STATE_RESP: state_d = MEM_STATE_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= MEM_STATE_IDLE;
      cnt_q     <= '0;
      pend_i_q  <= 1'b0;
      pend_d_q  <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      cap_i_q   <= 1'b0;
      cap_d_q   <= 1'b0;
      i_addr_q  <= '0;
      d_addr_q  <= '0;
      wdata_q   <= '0;
      ibus_in_q <= '0;
      dbus_in_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == MEM_STATE_IDLE) begin
        pend_i_q <= ibus_fetch;
        pend_d_q <= dreq;
        rd_q     <= dbus_read;
        wr_q     <= dbus_write;
        i_addr_q <= ibus_addr[ADDR_BITS-1:0];
        d_addr_q <= dbus_addr[ADDR_BITS-1:0];
        wdata_q  <= dbus_output;
      end
      // RAM data lands one cycle after the final ACC edge
      cap_d_q <= last & (state_q == MEM_STATE_D_ACC) & rd_q;
      cap_i_q <= last & (state_q == MEM_STATE_I_ACC);
      if (cap_d_q) dbus_in_q <= ram_rdata;
      if (cap_i_q) ibus_in_q <= ram_rdata;
    end
  end

  assign ram_addr = (state_q == MEM_STATE_I_ACC) ? i_addr_q
                                                 : d_addr_q;
  assign ram_we   = last & (state_q == MEM_STATE_D_ACC) & wr_q;

  mesm6_ram #(
    .ADDR_BITS(ADDR_BITS),
    .INIT_FILE(INIT_FILE)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (ram_we),
    .addr_i (ram_addr),
    .wdata_i(wdata_q),
    .rdata_o(ram_rdata)
  );

  assign ibus_input = cap_i_q ? ram_rdata : ibus_in_q;
  assign dbus_input = cap_d_q ? ram_rdata : dbus_in_q;
  assign ibus_done  = (state_q == MEM_STATE_RESP) & pend_i_q;
  assign dbus_done  = (state_q == MEM_STATE_RESP) & pend_d_q;

endmodule

// File: tb/tb_mesm6_memctl.sv
// Scoreboard bench for mesm6_memctl: directed scenarios plus random
// traffic against an associative-array memory model.
module tb_mesm6_memctl;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ibus_fetch = 1'b0;
  logic [14:0] ibus_addr = '0;
  logic [47:0] ibus_input;
  logic        ibus_done;
  logic        dbus_read = 1'b0;
  logic        dbus_write = 1'b0;
  logic [14:0] dbus_addr = '0;
  logic [47:0] dbus_output = '0;
  logic [47:0] dbus_input;
  logic        dbus_done;

  mesm6_memctl #(
    .ADDR_BITS(15),
    .WAIT_STATES(W),
    .INIT_FILE("")
  ) dut (
    .clk(clk), .reset(reset),
    .ibus_fetch(ibus_fetch), .ibus_addr(ibus_addr),
    .ibus_input(ibus_input), .ibus_done(ibus_done),
    .dbus_read(dbus_read), .dbus_write(dbus_write),
    .dbus_addr(dbus_addr), .dbus_output(dbus_output),
    .dbus_input(dbus_input), .dbus_done(dbus_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [47:0] data;
    int          due;
    bit          chk;
  } exp_t;

  exp_t iq[$];
  exp_t dq[$];
  logic [47:0] model [logic [14:0]];

  int checks = 0;
  int passes = 0;

  function automatic void check(string name, logic [47:0] act,
                                logic [47:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endfunction

  function automatic logic [47:0] peek(logic [14:0] a);
    return model.exists(a) ? model[a] : 48'h0;
  endfunction

  // monitor: pops the scoreboard whenever a done pulse shows up
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (dbus_done) begin
        if (dq.size() == 0) check("dbus_done unexpected", 48'd1, 48'd0);
        else begin
          e = dq.pop_front();
          check("dbus_done cycle", 48'(cyc), 48'(e.due));
          if (e.chk) check("dbus_input", dbus_input, e.data);
        end
      end
      if (ibus_done) begin
        if (iq.size() == 0) check("ibus_done unexpected", 48'd1, 48'd0);
        else begin
          e = iq.pop_front();
          check("ibus_done cycle", 48'(cyc), 48'(e.due));
          check("ibus_input", ibus_input, e.data);
        end
      end
    end
  end

  // Called #1 after a rising edge with the DUT idle; returns in the
  // idle cycle following the response.
  task automatic issue(input bit f, input bit r, input bit w,
                       input logic [14:0] ia, input logic [14:0] da,
                       input logic [47:0] wd);
    exp_t e;
    int   c0, t, lat;
    c0  = cyc;
    lat = (f && (r || w)) ? 2*W + 3 : W + 2;
    if (r || w) begin
      e.data = peek(da);
      e.due  = c0 + lat;
      e.chk  = r;
      dq.push_back(e);
      if (w) model[da] = wd;
    end
    if (f) begin
      e.data = peek(ia);
      e.due  = c0 + lat;
      e.chk  = 1'b1;
      iq.push_back(e);
    end
    ibus_fetch = f; ibus_addr = ia;
    dbus_read = r; dbus_write = w;
    dbus_addr = da; dbus_output = wd;
    t = 0;
    do begin
      @(posedge clk);
      t++;
    end while ((iq.size() != 0 || dq.size() != 0) && t < 40);
    #1;
    if (t >= 40) begin
      check("done timeout", 48'd1, 48'd0);
      iq.delete();
      dq.delete();
    end
    ibus_fetch = 1'b0;
    dbus_read  = 1'b0;
    dbus_write = 1'b0;
  endtask

  task automatic wr(input logic [14:0] a, input logic [47:0] d);
    issue(1'b0, 1'b0, 1'b1, 15'd0, a, d);
  endtask

  task automatic rd(input logic [14:0] a);
    issue(1'b0, 1'b1, 1'b0, 15'd0, a, 48'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [47:0] old40;
    repeat (3) @(posedge clk);
    #1;
    check("reset ibus_input", ibus_input, 48'd0);
    check("reset dbus_input", dbus_input, 48'd0);
    check("reset ibus_done", 48'(ibus_done), 48'd0);
    check("reset dbus_done", 48'(dbus_done), 48'd0);
    reset = 1'b0;
    idle(2);

    wr(15'o00010, 48'o1234567012345670);
    wr(15'o00020, 48'h1111_2222_3333);
    wr(15'o00030, 48'd5);
    wr(15'o00040, 48'h4040_4040_4040);
    wr(15'o00101, 48'h0101_0101_0101);
    for (int i = 0; i < 16; i++)
      wr(15'o00200 + 15'(i), 48'({$urandom(), $urandom()}));
    idle(1);

    issue(1'b1, 1'b0, 1'b0, 15'o00010, 15'd0, 48'd0);
    idle(2);
    wr(15'o00100, 48'h0000_DEAD_BEEF);
    rd(15'o00100);
    rd(15'o00101);
    idle(1);
    issue(1'b1, 1'b1, 1'b0, 15'o00010, 15'o00020, 48'd0);
    idle(1);
    issue(1'b0, 1'b1, 1'b1, 15'd0, 15'o00030, 48'd7);
    rd(15'o00030);

    // write aborted by reset in its second cycle
    old40 = peek(15'o00040);
    dbus_write = 1'b1; dbus_addr = 15'o00040;
    dbus_output = 48'hBAD0_BAD0_BAD0;
    idle(2);
    reset = 1'b1;
    dbus_write = 1'b0;
    #2;
    check("abort ibus_input", ibus_input, 48'd0);
    check("abort dbus_input", dbus_input, 48'd0);
    check("abort ibus_done", 48'(ibus_done), 48'd0);
    check("abort dbus_done", 48'(dbus_done), 48'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(W + 4);
    rd(15'o00040);
    check("abort model kept", peek(15'o00040), old40);
    issue(1'b1, 1'b0, 1'b0, 15'o00010, 15'd0, 48'd0);

    // back-to-back reads, no idle gap
    rd(15'o00200);
    rd(15'o00201);
    rd(15'o00202);
    rd(15'o00203);

    for (int n = 0; n < 80; n++) begin
      logic [14:0] ia, da;
      bit f, r, w;
      ia = 15'o00200 + 15'($urandom_range(0, 15));
      da = 15'o00200 + 15'($urandom_range(0, 15));
      f = 1'($urandom);
      r = 1'($urandom);
      w = 1'($urandom);
      if (!f && !r && !w) r = 1'b1;
      issue(f, r, w, ia, da, 48'({$urandom(), $urandom()}));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    idle(W + 6);
    check("ibus queue drained", 48'(iq.size()), 48'd0);
    check("dbus queue drained", 48'(dq.size()), 48'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
